tmr_sched: RTL and testbench

- Round-robin scheduler that shares one down-counter delay engine among NUM_REQ requesters.
- Each requester asks for a one-shot delay of reqDelay ticks of pulseClk. The scheduler grants one request at a time and runs it through a load/count/fire sequence.
- On expiry it emits a one-cycle done pulse to the owning requester.
- Sits between the pulse-timing consumers and the shared reconfigurable timer resource; replaces per-consumer timers.

---
 rtl/tmr_pkg.sv | 34 +++
 rtl/tmr_rr_pick.sv | 21 ++
 rtl/tmr_sched.sv | 134 +++++++++++++
 tb/tb_tmr_sched.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tmr_pkg.sv
// tmr_pkg: shared definitions for the timer scheduler.
//   state_e    : FSM encoding (S_IDLE=0, S_COUNT=1)
//   CNT_W_DEF  : default delay/counter width
//   MAX_REQ    : largest supported requester count
//   rrPick()   : round-robin pick index for a request vector and start pointer
package tmr_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_e;

    localparam int CNT_W_DEF = 8;
    localparam int MAX_REQ   = 8;

    // First set bit of req at or above ptr, wrapping modulo numReq.
    // Walks offsets from far to near so the nearest hit is written last.
    // Returns 0 when req is empty; the caller qualifies with its own hit flag.
    function automatic int rrPick(input logic [31:0] req, input int numReq, input int ptr);
        int pick;
        pick = 0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < numReq) begin
                int j;
                logic [31:0] sh;
                j  = (ptr + k) % numReq;
                sh = req >> j;
                if (sh[0]) pick = j;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/tmr_rr_pick.sv
// tmr_rr_pick: combinational rotate-priority encoder.
//   req [NUM_REQ] : request vector
//   ptr [ID_W]    : highest-priority index
//   hit           : any request present
//   idx [ID_W]    : first request found from ptr upward, wrapping
module tmr_rr_pick
    import tmr_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               hit,
    output logic [ID_W-1:0]    idx
);

    assign hit = |req;
    assign idx = ID_W'(rrPick(32'(req), NUM_REQ, int'(ptr)));

endmodule

// File: rtl/tmr_sched.sv
// tmr_sched: round-robin scheduler sharing one down-counter delay engine
// among NUM_REQ requesters. A granted job loads its delay, counts down to 0
// and then fires a one-cycle done pulse to its owner.
//   pulseClk  : clock, rising edge
//   rst       : synchronous active-high reset
//   reqValid  : per-requester request, held until granted
//   reqDelay  : packed delays, requester i at [i*CNT_W +: CNT_W]
//   abort     : cancel the running job, no done pulse
//   reqGrant  : one-hot one-cycle grant pulse
//   donePulse : one-hot one-cycle expiry pulse
//   busy      : job loaded or counting
//   activeId  : current or last granted requester
//   cntRemain : live counter value (only with TMR_SCHED_CNT_OUT_EN defined)
module tmr_sched
    import tmr_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int CNT_W   = CNT_W_DEF,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     pulseClk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       reqValid,
    input  logic [NUM_REQ*CNT_W-1:0] reqDelay,
    input  logic                     abort,
    output logic [NUM_REQ-1:0]       reqGrant,
    output logic [NUM_REQ-1:0]       donePulse,
    output logic                     busy,
    output logic [ID_W-1:0]          activeId
`ifdef TMR_SCHED_CNT_OUT_EN
    ,
    output logic [CNT_W-1:0]         cntRemain
`endif
);

    state_e state, stateNext;

    logic [CNT_W-1:0]   counter, counterNext;
    logic [ID_W-1:0]    rrPtr, rrPtrNext;
    logic [NUM_REQ-1:0] grantNext, doneNext;
    logic               busyNext;
    logic [ID_W-1:0]    activeIdNext;

    logic               pickHit;
    logic [ID_W-1:0]    pickIdx;
    logic [CNT_W-1:0]   delArr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : gDel
        assign delArr[g] = reqDelay[g*CNT_W +: CNT_W];
    end

    tmr_rr_pick #(.NUM_REQ(NUM_REQ)) uPick (
        .req (reqValid),
        .ptr (rrPtr),
        .hit (pickHit),
        .idx (pickIdx)
    );

    // State register
    always_ff @(posedge pulseClk) begin
        if (rst) state <= S_IDLE;
        else     state <= stateNext;
    end

    // Next state; abort only matters while counting and beats expiry
    always_comb begin
        stateNext = state;
        case (state)
            S_IDLE:  if (pickHit) stateNext = S_COUNT;
            S_COUNT: if (abort || counter == '0) stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        counterNext  = counter;
        rrPtrNext    = rrPtr;
        grantNext    = '0;
        doneNext     = '0;
        busyNext     = busy;
        activeIdNext = activeId;
        case (state)
            S_IDLE: begin
                if (pickHit) begin
                    counterNext        = delArr[pickIdx];
                    activeIdNext       = pickIdx;
                    grantNext[pickIdx] = 1'b1;
                    rrPtrNext          = (pickIdx == ID_W'(NUM_REQ - 1)) ? '0 : pickIdx + ID_W'(1);
                    busyNext           = 1'b1;
                end
            end
            S_COUNT: begin
                if (abort) begin
                    counterNext = '0;
                    busyNext    = 1'b0;
                end else if (counter == '0) begin
                    doneNext[activeId] = 1'b1;
                    busyNext           = 1'b0;
                end else begin
                    counterNext = counter - CNT_W'(1);
                end
            end
            default: begin
                counterNext = '0;
                busyNext    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pulseClk) begin
        if (rst) begin
            counter   <= '0;
            rrPtr     <= '0;
            reqGrant  <= '0;
            donePulse <= '0;
            busy      <= 1'b0;
            activeId  <= '0;
        end else begin
            counter   <= counterNext;
            rrPtr     <= rrPtrNext;
            reqGrant  <= grantNext;
            donePulse <= doneNext;
            busy      <= busyNext;
            activeId  <= activeIdNext;
        end
    end

`ifdef TMR_SCHED_CNT_OUT_EN
    // Counter is forced to 0 on expiry, abort and reset, so it reads 0 in IDLE
    assign cntRemain = counter;
`endif

endmodule

// File: tb/tb_tmr_sched.sv
// tb_tmr_sched: directed, table-driven bench for tmr_sched (NUM_REQ=4, CNT_W=8).
// Each table row gives the inputs applied before one clock edge and the
// outputs expected just after it. Hand sequences cover reset mid-count and
// the maximum delay (with cntRemain walk when TMR_SCHED_CNT_OUT_EN is set).
module tb_tmr_sched;

    logic        pulseClk;
    logic        rst;
    logic [3:0]  reqValid;
    logic [31:0] reqDelay;
    logic        abort;
    logic [3:0]  reqGrant;
    logic [3:0]  donePulse;
    logic        busy;
    logic [1:0]  activeId;
`ifdef TMR_SCHED_CNT_OUT_EN
    logic [7:0]  cntRemain;
`endif

    int nChecks = 0;
    int nErrors = 0;

    tmr_sched #(.NUM_REQ(4), .CNT_W(8)) dut (
        .pulseClk  (pulseClk),
        .rst       (rst),
        .reqValid  (reqValid),
        .reqDelay  (reqDelay),
        .abort     (abort),
        .reqGrant  (reqGrant),
        .donePulse (donePulse),
        .busy      (busy),
        .activeId  (activeId)
`ifdef TMR_SCHED_CNT_OUT_EN
        ,
        .cntRemain (cntRemain)
`endif
    );

    initial pulseClk = 1'b0;
    always #5 pulseClk = ~pulseClk;

    typedef struct {
        logic        rst;
        logic [3:0]  rv;
        logic [31:0] dly;
        logic        ab;
        logic [3:0]  eg;
        logic [3:0]  ed;
        logic        eb;
        logic [1:0]  ea;
    } vec_t;

    vec_t vecs[$];

    task automatic addV(input int r, input int rv, input logic [31:0] dly, input int ab,
                        input int eg, input int ed, input int eb, input int ea);
        vec_t v;
        v.rst = 1'(r);
        v.rv  = 4'(rv);
        v.dly = dly;
        v.ab  = 1'(ab);
        v.eg  = 4'(eg);
        v.ed  = 4'(ed);
        v.eb  = 1'(eb);
        v.ea  = 2'(ea);
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pulseClk);
        #1;
    endtask

    initial begin
        int bad;
        int n;
        int busyBad;
        int cntBad;

        rst      = 1'b1;
        reqValid = '0;
        reqDelay = '0;
        abort    = 1'b0;

        //    rst rv      dly           ab  grant    done     busy aid
        // reset, then single request delay 3 (delay changed after grant)
        addV(1, 'b0000, 32'h00000000, 0, 'b0000, 'b0000, 0, 0);
        addV(1, 'b0000, 32'h00000000, 0, 'b0000, 'b0000, 0, 0);
        addV(0, 'b0001, 32'h00000003, 0, 'b0001, 'b0000, 1, 0);
        addV(0, 'b0000, 32'h000000FF, 0, 'b0000, 'b0000, 1, 0);
        addV(0, 'b0000, 32'h000000FF, 0, 'b0000, 'b0000, 1, 0);
        addV(0, 'b0000, 32'h000000FF, 0, 'b0000, 'b0000, 1, 0);
        addV(0, 'b0000, 32'h000000FF, 0, 'b0000, 'b0001, 0, 0);
        addV(0, 'b0000, 32'h000000FF, 0, 'b0000, 'b0000, 0, 0);
        // zero delay on requester 2
        addV(0, 'b0100, 32'h05000505, 0, 'b0100, 'b0000, 1, 2);
        addV(0, 'b0000, 32'h05000505, 0, 'b0000, 'b0100, 0, 2);
        // reset clears rrPtr, then full contention with delay 1
        addV(1, 'b0000, 32'h01010101, 0, 'b0000, 'b0000, 0, 0);
        addV(0, 'b1111, 32'h01010101, 0, 'b0001, 'b0000, 1, 0);
        addV(0, 'b1111, 32'h01010101, 0, 'b0000, 'b0000, 1, 0);
        addV(0, 'b1111, 32'h01010101, 0, 'b0000, 'b0001, 0, 0);
        addV(0, 'b1111, 32'h01010101, 0, 'b0010, 'b0000, 1, 1);
        addV(0, 'b1111, 32'h01010101, 0, 'b0000, 'b0000, 1, 1);
        addV(0, 'b1111, 32'h01010101, 0, 'b0000, 'b0010, 0, 1);
        addV(0, 'b1111, 32'h01010101, 0, 'b0100, 'b0000, 1, 2);
        addV(0, 'b1111, 32'h01010101, 0, 'b0000, 'b0000, 1, 2);
        addV(0, 'b1111, 32'h01010101, 0, 'b0000, 'b0100, 0, 2);
        addV(0, 'b1111, 32'h01010101, 0, 'b1000, 'b0000, 1, 3);
        addV(0, 'b1111, 32'h01010101, 0, 'b0000, 'b0000, 1, 3);
        addV(0, 'b1111, 32'h01010101, 0, 'b0000, 'b1000, 0, 3);
        addV(0, 'b1111, 32'h01010101, 0, 'b0001, 'b0000, 1, 0);
        addV(0, 'b0000, 32'h01010101, 0, 'b0000, 'b0000, 1, 0);
        addV(0, 'b0000, 32'h01010101, 0, 'b0000, 'b0001, 0, 0);
        // abort on the expiry cycle, pending requester 3 granted next edge
        addV(0, 'b0010, 32'h01000200, 0, 'b0010, 'b0000, 1, 1);
        addV(0, 'b1000, 32'h01000200, 0, 'b0000, 'b0000, 1, 1);
        addV(0, 'b1000, 32'h01000200, 0, 'b0000, 'b0000, 1, 1);
        addV(0, 'b1000, 32'h01000200, 1, 'b0000, 'b0000, 0, 1);
        addV(0, 'b1000, 32'h01000200, 0, 'b1000, 'b0000, 1, 3);
        addV(0, 'b0000, 32'h01000200, 0, 'b0000, 'b0000, 1, 3);
        addV(0, 'b0000, 32'h01000200, 0, 'b0000, 'b1000, 0, 3);
        // abort in IDLE is ignored
        addV(0, 'b0001, 32'h00000000, 1, 'b0001, 'b0000, 1, 0);
        addV(0, 'b0000, 32'h00000000, 0, 'b0000, 'b0001, 0, 0);
        addV(0, 'b0000, 32'h00000000, 0, 'b0000, 'b0000, 0, 0);

        foreach (vecs[i]) begin
            rst      = vecs[i].rst;
            reqValid = vecs[i].rv;
            reqDelay = vecs[i].dly;
            abort    = vecs[i].ab;
            tick();
            check($sformatf("row%0d grant", i), 32'(reqGrant),  32'(vecs[i].eg));
            check($sformatf("row%0d done",  i), 32'(donePulse), 32'(vecs[i].ed));
            check($sformatf("row%0d busy",  i), 32'(busy),      32'(vecs[i].eb));
            check($sformatf("row%0d aid",   i), 32'(activeId),  32'(vecs[i].ea));
        end
        abort = 1'b0;

        // Reset in the middle of a long job (rrPtr is 1 here; grant 2 moves it to 3)
        reqValid = 4'b0100;
        reqDelay = 32'h00C80000;
        tick();
        check("mid grant", 32'(reqGrant), 32'h4);
        reqValid = 4'b0000;
        bad = 0;
        repeat (50) begin
            tick();
            if (donePulse !== 4'b0000 || busy !== 1'b1) bad++;
        end
        check("mid running", 32'(bad), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid rst grant", 32'(reqGrant),  32'd0);
        check("mid rst done",  32'(donePulse), 32'd0);
        check("mid rst busy",  32'(busy),      32'd0);
        check("mid rst aid",   32'(activeId),  32'd0);
`ifdef TMR_SCHED_CNT_OUT_EN
        check("mid rst cnt",   32'(cntRemain), 32'd0);
`endif
        bad = 0;
        repeat (5) begin
            tick();
            if (donePulse !== 4'b0000 || busy !== 1'b0) bad++;
        end
        check("mid after rst quiet", 32'(bad), 32'd0);
        reqValid = 4'b1010;
        reqDelay = 32'h00000000;
        tick();
        check("mid post grant", 32'(reqGrant), 32'h2);
        check("mid post aid",   32'(activeId), 32'd1);
        reqValid = 4'b0000;
        tick();
        check("mid post done",  32'(donePulse), 32'h2);

        // Maximum delay: done at grant edge + 256 edges
        reqValid = 4'b0001;
        reqDelay = 32'h000000FF;
        tick();
        check("max grant", 32'(reqGrant), 32'h1);
        reqValid = 4'b0000;
        n = 0;
        busyBad = 0;
        cntBad = 0;
        for (int k = 1; k <= 400; k++) begin
`ifdef TMR_SCHED_CNT_OUT_EN
            if (cntRemain !== 8'(256 - k)) cntBad++;
`endif
            if (busy !== 1'b1) busyBad++;
            tick();
            if (donePulse !== 4'b0000) begin
                n = k;
                break;
            end
        end
        check("max latency",  32'(n), 32'd256);
        check("max done id",  32'(donePulse), 32'h1);
        check("max busy run", 32'(busyBad), 32'd0);
        check("max cnt walk", 32'(cntBad), 32'd0);
        check("max busy end", 32'(busy), 32'd0);
`ifdef TMR_SCHED_CNT_OUT_EN
        check("max cnt end",  32'(cntRemain), 32'd0);
`endif
        tick();
        check("max done one-shot", 32'(donePulse), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
